branch_resolve_ctrl: RTL and testbench
======================================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk_i  input  1  rising-edge clock.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 ex_valid_i  input  1  EX-stage instruction is a valid conditional branch.
REQ-005 ex_funct3_i  input  3  branch funct3 of the EX instruction.
REQ-006 ex_pc_i  input  32  PC of the EX branch.
REQ-007 ex_target_i  input  32  computed taken-target of the EX branch.
REQ-008 ex_pred_taken_i  input  1  prediction carried down from fetch.
REQ-009 BrUn_o  output  1  unsigned-compare select driven to the branch comparator.
REQ-010 BrEq_i, BrLt_i, BrGe_i  input  1 each  branch comparator results.
REQ-011 if_pc_i  input  32  fetch PC for prediction lookup.
REQ-012 pred_taken_o  output  1  prediction for if_pc_i.
REQ-013 redirect_o  output  1  fetch redirect request.
REQ-014 redirect_pc_o  output  32  redirect destination.
REQ-015 redirect_ready_i  input  1  fetch accepts the redirect.
REQ-016 flush_o  output  1  flush IF/ID and ID/EX.
REQ-017 hold_o  output  1  stall the pipeline front-end and EX.
REQ-018 illegal_o  output  1  one-cycle pulse on a reserved funct3.
REQ-019 br_cnt_o, mispred_cnt_o  output  32 each  resolved-branch and misprediction counters.

Function
REQ-020 BrUn_o SHALL equal ex_funct3_i[1] combinationally.
REQ-021 Taken decode SHALL be: 000 BrEq_i; 001 !BrEq_i; 100/110 BrLt_i; 101/111 BrGe_i.
REQ-022 Reserved funct3 010/011 SHALL resolve not-taken, pulse illegal_o next cycle, skip BHT and counter updates, and never redirect.
REQ-023 A branch SHALL be evaluated only on a rising edge with ex_valid_i=1 and state IDLE.
REQ-024 Mispredict SHALL mean taken != ex_pred_taken_i.
REQ-025 On a mispredict the FSM SHALL enter REDIRECT one cycle later, latching redirect_pc_o = taken ? ex_target_i : ex_pc_i+4 (mod 2^32).
REQ-026 In REDIRECT: redirect_o=1, hold_o=1, flush_o=1. The FSM SHALL stay in REDIRECT, with redirect_pc_o stable, until redirect_ready_i=1, then return to IDLE on that edge.
REQ-027 If redirect_ready_i=1 on the first REDIRECT cycle, redirect_o SHALL be high for exactly one cycle.
REQ-028 ex_valid_i in REDIRECT SHALL be ignored: no evaluation, BHT update or count.
REQ-029 In IDLE, redirect_o, flush_o and hold_o SHALL be 0.
REQ-030 The BHT SHALL have 16 two-bit saturating counters indexed by pc[5:2].
REQ-031 pred_taken_o SHALL equal the MSB of entry if_pc_i[5:2], read combinationally.
REQ-032 On an evaluated legal branch, entry ex_pc_i[5:2] SHALL increment if taken and decrement if not taken, saturating at 11 and 00.
REQ-033 A same-cycle read and write of one BHT index SHALL return the pre-update value.
REQ-034 br_cnt_o SHALL increment on each evaluated legal branch.
REQ-035 mispred_cnt_o SHALL increment on each mispredict.
REQ-036 Both counters SHALL saturate at 0xFFFFFFFF.

Reset
REQ-037 rst_i SHALL take effect at the next edge from any state, including mid-REDIRECT, and abandon a pending redirect.
REQ-038 Reset values SHALL be: state IDLE, BHT entries 01, both counters 0, redirect_pc_o 0, illegal_o 0.

Structure
REQ-039 Package branch_ctrl_pkg SHALL hold:
- funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU);
- FSM state enum {IDLE, REDIRECT};
- BHT_ENTRIES=16, BHT_IDX_W=4;
- counter encodings SNT=00, WNT=01, WT=10, ST=11.
REQ-040 Sub-module branch_bht SHALL hold the predictor (one read port, one update port).

Verification
REQ-041 Reset, then BEQ at pc 0x100 with BrEq_i=1 and pred 0: redirect_o high next cycle with redirect_pc_o = target; BHT[0] becomes 10; mispred_cnt_o=1.
REQ-042 BLTU with pred 1 and BrLt_i=0 at pc 0x204, redirect_ready_i low for 3 cycles: redirect_o, hold_o and flush_o high for 4 cycles; redirect_pc_o=0x208 throughout.
REQ-043 Six taken branches at one index: the counter saturates at 11; pred_taken_o=1; br_cnt_o=6.
REQ-044 funct3=011 with ex_valid_i=1: illegal_o pulses once; no redirect; counters unchanged.
REQ-045 rst_i asserted during REDIRECT: next cycle redirect_o=0, BHT all 01, counters 0.
REQ-046 ex_pc_i=0xFFFFFFFC, not taken, mispredicted: redirect_pc_o=0x00000000.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the branch resolution controller:
// funct3 codes, FSM states, BHT geometry and 2-bit counter encodings.
package branch_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    localparam int BHT_ENTRIES = 16;
    localparam int BHT_IDX_W   = 4;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// 16-entry table of 2-bit saturating counters; combinational read port,
// registered update port, so a same-index read sees the pre-update value.
module branch_bht
    import branch_ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BHT_IDX_W-1:0] rd_idx_i,
    output logic [1:0]           rd_ctr_o,
    input  logic                 wr_en_i,
    input  logic [BHT_IDX_W-1:0] wr_idx_i,
    input  logic                 wr_taken_i
);

    logic [1:0] ctr_q [BHT_ENTRIES];
    logic [1:0] ctr_d [BHT_ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en_i) begin
            ctr_d[wr_idx_i] = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves EX-stage conditional branches, trains the BHT, counts branches
// and mispredictions, and holds a fetch redirect until it is accepted.
//
// state    | meaning
// IDLE     | evaluating valid EX branches; no redirect outstanding
// REDIRECT | redirect/flush/hold asserted until redirect_ready_i
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    output logic        BrUn_o,
    input  logic        BrEq_i,
    input  logic        BrLt_i,
    input  logic        BrGe_i,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        flush_o,
    output logic        hold_o,
    output logic        illegal_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    state_e      state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        illegal_q, illegal_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic        taken, legal, eval, upd, mispred;
    logic [1:0]  rd_ctr;
    logic        unused_if_pc;

    assign BrUn_o = ex_funct3_i[1];

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (ex_funct3_i)
            F3_BEQ:          taken = BrEq_i;
            F3_BNE:          taken = !BrEq_i;
            F3_BLT, F3_BLTU: taken = BrLt_i;
            F3_BGE, F3_BGEU: taken = BrGe_i;
            default:         legal = 1'b0;
        endcase
    end

    assign eval    = ex_valid_i && (state_q == IDLE);
    assign upd     = eval && legal;
    assign mispred = upd && (taken != ex_pred_taken_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mispred) state_d = REDIRECT;
            REDIRECT: if (redirect_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        redirect_o = (state_q == REDIRECT);
        flush_o    = (state_q == REDIRECT);
        hold_o     = (state_q == REDIRECT);
    end

    // Redirect target is captured once and held for the whole REDIRECT stay.
    always_comb begin
        redirect_pc_d = redirect_pc_q;
        if (mispred) begin
            redirect_pc_d = taken ? ex_target_i : ex_pc_i + 32'd4;
        end
        illegal_d     = eval && !legal;
        br_cnt_d      = (upd && br_cnt_q != '1) ? br_cnt_q + 32'd1 : br_cnt_q;
        mispred_cnt_d = (mispred && mispred_cnt_q != '1) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_pc_q <= '0;
            illegal_q     <= 1'b0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            redirect_pc_q <= redirect_pc_d;
            illegal_q     <= illegal_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign redirect_pc_o = redirect_pc_q;
    assign illegal_o     = illegal_q;
    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    branch_bht u_bht (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (if_pc_i[5:2]),
        .rd_ctr_o   (rd_ctr),
        .wr_en_i    (upd),
        .wr_idx_i   (ex_pc_i[5:2]),
        .wr_taken_i (taken)
    );

    assign pred_taken_o = rd_ctr[1];
    assign unused_if_pc = ^{if_pc_i[31:6], if_pc_i[1:0], rd_ctr[0]};

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with hand-computed expectations.
module tb_branch_resolve_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic        BrUn_o;
    logic        BrEq_i, BrLt_i, BrGe_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        flush_o, hold_o, illegal_o;
    logic [31:0] br_cnt_o, mispred_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_resolve_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ex_valid_i       (ex_valid_i),
        .ex_funct3_i      (ex_funct3_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .BrUn_o           (BrUn_o),
        .BrEq_i           (BrEq_i),
        .BrLt_i           (BrLt_i),
        .BrGe_i           (BrGe_i),
        .if_pc_i          (if_pc_i),
        .pred_taken_o     (pred_taken_o),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .flush_o          (flush_o),
        .hold_o           (hold_o),
        .illegal_o        (illegal_o),
        .br_cnt_o         (br_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_redir(input string tag, input logic exp, input logic [31:0] exp_pc);
        check({tag, "_redirect"}, {31'd0, redirect_o}, {31'd0, exp});
        check({tag, "_hold"},     {31'd0, hold_o},     {31'd0, exp});
        check({tag, "_flush"},    {31'd0, flush_o},    {31'd0, exp});
        check({tag, "_rpc"},      redirect_pc_o,       exp_pc);
    endtask

    initial begin
        rst_i = 1'b1; ex_valid_i = 1'b0; ex_funct3_i = 3'b000; ex_pc_i = '0;
        ex_target_i = '0; ex_pred_taken_i = 1'b0; BrEq_i = 1'b0; BrLt_i = 1'b0;
        BrGe_i = 1'b0; if_pc_i = '0; redirect_ready_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;

        // reset state
        check_redir("rst", 1'b0, 32'h0);
        check("rst_illegal", {31'd0, illegal_o}, 32'd0);
        check("rst_br_cnt", br_cnt_o, 32'd0);
        check("rst_mis_cnt", mispred_cnt_o, 32'd0);
        check("rst_pred", {31'd0, pred_taken_o}, 32'd0);

        // BEQ taken, predicted not-taken, pc 0x100 -> redirect to target
        ex_valid_i = 1'b1; ex_funct3_i = 3'b000; ex_pc_i = 32'h100; ex_target_i = 32'h180;
        ex_pred_taken_i = 1'b0; BrEq_i = 1'b1; if_pc_i = 32'h100;
        #1;
        check("beq_brun", {31'd0, BrUn_o}, 32'd0);
        check("beq_pred_pre", {31'd0, pred_taken_o}, 32'd0);
        tick();
        ex_valid_i = 1'b0;
        check_redir("beq", 1'b1, 32'h180);
        check("beq_mis_cnt", mispred_cnt_o, 32'd1);
        check("beq_br_cnt", br_cnt_o, 32'd1);
        check("beq_pred_post", {31'd0, pred_taken_o}, 32'd1);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        check_redir("beq_done", 1'b0, 32'h180);

        // BLTU not taken, predicted taken, pc 0x204, ready held low 3 cycles
        ex_valid_i = 1'b1; ex_funct3_i = 3'b110; ex_pc_i = 32'h204; ex_target_i = 32'h300;
        ex_pred_taken_i = 1'b1; BrEq_i = 1'b0; BrLt_i = 1'b0; BrGe_i = 1'b1;
        #1;
        check("bltu_brun", {31'd0, BrUn_o}, 32'd1);
        tick();
        // a would-be mispredict presented during REDIRECT must be ignored
        ex_funct3_i = 3'b000; ex_pc_i = 32'h100; ex_target_i = 32'h700;
        ex_pred_taken_i = 1'b0; BrEq_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_redir("bltu_wait", 1'b1, 32'h208);
            tick();
        end
        ex_valid_i = 1'b0;
        check_redir("bltu_last", 1'b1, 32'h208);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        check_redir("bltu_done", 1'b0, 32'h208);
        check("bltu_br_cnt", br_cnt_o, 32'd2);
        check("bltu_mis_cnt", mispred_cnt_o, 32'd2);
        if_pc_i = 32'h204;
        #1;
        check("bltu_pred", {31'd0, pred_taken_o}, 32'd0);

        // six correctly-predicted taken BEQs at index 2
        ex_valid_i = 1'b1; ex_funct3_i = 3'b000; ex_pc_i = 32'h108; ex_target_i = 32'h400;
        ex_pred_taken_i = 1'b1; BrEq_i = 1'b1; if_pc_i = 32'h108;
        #1;
        check("sat_pred_pre", {31'd0, pred_taken_o}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("sat_no_redir", {31'd0, redirect_o}, 32'd0);
        end
        ex_valid_i = 1'b0;
        check("sat_pred", {31'd0, pred_taken_o}, 32'd1);
        check("sat_br_cnt", br_cnt_o, 32'd8);
        check("sat_mis_cnt", mispred_cnt_o, 32'd2);

        // BNE not taken, correctly predicted
        ex_valid_i = 1'b1; ex_funct3_i = 3'b001; ex_pc_i = 32'h110; ex_pred_taken_i = 1'b0;
        BrEq_i = 1'b1;
        tick();
        ex_valid_i = 1'b0;
        check("bne_no_redir", {31'd0, redirect_o}, 32'd0);
        check("bne_br_cnt", br_cnt_o, 32'd9);

        // BGE taken, predicted not-taken
        ex_valid_i = 1'b1; ex_funct3_i = 3'b101; ex_pc_i = 32'h120; ex_target_i = 32'h500;
        ex_pred_taken_i = 1'b0; BrEq_i = 1'b0; BrLt_i = 1'b0; BrGe_i = 1'b1;
        tick();
        ex_valid_i = 1'b0;
        check_redir("bge", 1'b1, 32'h500);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        check("bge_done", {31'd0, redirect_o}, 32'd0);
        check("bge_mis_cnt", mispred_cnt_o, 32'd3);

        // reserved funct3 011
        ex_valid_i = 1'b1; ex_funct3_i = 3'b011; ex_pc_i = 32'h130; ex_pred_taken_i = 1'b1;
        BrEq_i = 1'b1; BrLt_i = 1'b1; BrGe_i = 1'b1;
        tick();
        ex_valid_i = 1'b0;
        check("ill_pulse", {31'd0, illegal_o}, 32'd1);
        check("ill_no_redir", {31'd0, redirect_o}, 32'd0);
        check("ill_br_cnt", br_cnt_o, 32'd10);
        check("ill_mis_cnt", mispred_cnt_o, 32'd3);
        tick();
        check("ill_end", {31'd0, illegal_o}, 32'd0);
        check("ill_no_redir2", {31'd0, redirect_o}, 32'd0);

        // not-taken at top of address space wraps pc+4 to 0
        ex_valid_i = 1'b1; ex_funct3_i = 3'b000; ex_pc_i = 32'hFFFF_FFFC; ex_target_i = 32'h600;
        ex_pred_taken_i = 1'b1; BrEq_i = 1'b0;
        tick();
        ex_valid_i = 1'b0;
        check_redir("wrap", 1'b1, 32'h0);
        check("wrap_br_cnt", br_cnt_o, 32'd11);
        check("wrap_mis_cnt", mispred_cnt_o, 32'd4);
        tick();
        check("wrap_still", {31'd0, redirect_o}, 32'd1);

        // reset in the middle of REDIRECT
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_redir("mid_rst", 1'b0, 32'h0);
        check("mid_rst_br_cnt", br_cnt_o, 32'd0);
        check("mid_rst_mis_cnt", mispred_cnt_o, 32'd0);
        if_pc_i = 32'h100;
        #1;
        check("mid_rst_pred0", {31'd0, pred_taken_o}, 32'd0);
        if_pc_i = 32'h108;
        #1;
        check("mid_rst_pred2", {31'd0, pred_taken_o}, 32'd0);

        // entry 1 was 00 before reset; one taken from 01 must give 10
        ex_valid_i = 1'b1; ex_funct3_i = 3'b000; ex_pc_i = 32'h204; ex_pred_taken_i = 1'b1;
        BrEq_i = 1'b1; if_pc_i = 32'h204;
        tick();
        ex_valid_i = 1'b0;
        check("post_rst_pred1", {31'd0, pred_taken_o}, 32'd1);
        check("post_rst_br_cnt", br_cnt_o, 32'd1);
        check("post_rst_no_redir", {31'd0, redirect_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
